// File: rtl/rd_arb_pkg.sv
// rd_arb_pkg
//   Shared types and helpers for the 16-channel read-command arbiter.
//   Contents:
//     CH_NUM       number of requesting read channels (16)
//     RSP_DATA_W   response data width; follows `DATA_WIDTH (32 if undefined)
//     rsp_entry_t  response FIFO entry {idx, data}
//     rr_pick_t    round-robin search result {found, grant}
//     arb_state_e  grant-lock state used when burst locking is compiled in
//     rr_pick()    round-robin search starting at ptr and wrapping 15 -> 0

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package rd_arb_pkg;

  localparam int CH_NUM     = 16;
  localparam int RSP_DATA_W = `DATA_WIDTH;

  typedef struct packed {
    logic [3:0]            idx;
    logic [RSP_DATA_W-1:0] data;
  } rsp_entry_t;

  typedef struct packed {
    logic       found;
    logic [3:0] grant;
  } rr_pick_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

  // Walking the offsets from highest to lowest means the last hit written
  // is the one closest to ptr, which avoids needing an early exit.
  function automatic rr_pick_t rr_pick(input logic [CH_NUM-1:0] req,
                                       input logic [3:0]        ptr);
    rr_pick_t   res;
    logic [3:0] cand;
    res = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      cand = ptr + 4'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.grant = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rd_arb_rsp_fifo.sv
// rd_arb_rsp_fifo
//   Synchronous response FIFO holding {requester idx, read data} entries.
//   The head is read out of the storage flops, so an entry written on one
//   edge is visible at the output from the following cycle.
//   Ports:
//     iClk, iRst   clock, asynchronous active-high reset
//     push         write pushEntry (ignored when full)
//     pushEntry    entry to write
//     pop          remove the head entry (ignored when empty)
//     head         current head entry, all zero when empty
//     empty, full  occupancy flags
//     count        number of stored entries

module rd_arb_rsp_fifo
  import rd_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     push,
  input  rsp_entry_t               pushEntry,
  input  logic                     pop,
  output rsp_entry_t               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  rsp_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == (PTR_W + 1)'(DEPTH));
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge iClk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

  assign head = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/rd_cmd_arb16.sv
// rd_cmd_arb16
//   Round-robin arbiter sharing one fixed-latency SRAM read port among 16
//   read channels. One command is granted per cycle when a response credit
//   is available, the read is tagged with its requester and the returning
//   data is handed back in order through the response FIFO.
//   Optional feature macro: RDARB_BURST_LOCK_EN (grant stays on a channel
//   from a last=0 command until its last=1 command is accepted).
//   Ports:
//     iClk, iRst         clock, asynchronous active-high reset
//     iCmdVld/oCmdRdy    per-channel command handshake
//     iCmdPld            per-channel {last, addr}
//     oMemRen/oMemAddr   memory read request, same cycle as the accept
//     iMemData           memory data, RD_LAT cycles after oMemRen
//     oRspVld/iRspRdy    per-channel response handshake
//     oRspData           response data shared by all channels

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module rd_cmd_arb16
  import rd_arb_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = `DATA_WIDTH,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic [CH_NUM-1:0]              iCmdVld,
  output logic [CH_NUM-1:0]              oCmdRdy,
  input  logic [CH_NUM-1:0][ADDR_W:0]    iCmdPld,
  output logic                           oMemRen,
  output logic [ADDR_W-1:0]              oMemAddr,
  input  logic [DATA_W-1:0]              iMemData,
  output logic [CH_NUM-1:0]              oRspVld,
  output logic [DATA_W-1:0]              oRspData,
  input  logic [CH_NUM-1:0]              iRspRdy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  logic [3:0]        ptr;
  logic [RD_LAT-1:0] tagVld;
  logic [3:0]        tagIdx [RD_LAT];
  rr_pick_t          pick;
  logic [3:0]        grant;
  logic              found;
  logic              creditOk;
  logic              accept;
  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifoCount;
  rsp_entry_t        pushEntry;
  rsp_entry_t        fifoHead;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              fifoPop;

  // Every read still in the tag pipe or waiting in the FIFO holds a credit.
  // Both terms are registered, so a pop only returns its credit one cycle
  // later, which keeps the FIFO from ever being overrun.
  always_comb begin
    inflight = INF_W'(fifoCount);
    for (int k = 0; k < RD_LAT; k++) begin
      inflight = inflight + INF_W'(tagVld[k]);
    end
  end

  assign creditOk = inflight < INF_W'(FIFO_DEPTH);
  assign pick     = rr_pick(iCmdVld, ptr);

`ifdef RDARB_BURST_LOCK_EN
  arb_state_e state;
  arb_state_e stateNext;
  logic [3:0] lockCh;
  logic [3:0] lockChNext;

  // While locked only the burst owner can be granted; it may still stall
  // on credits or on its own valid.
  always_comb begin
    grant = pick.grant;
    found = pick.found;
    if (state == ARB_LOCKED) begin
      grant = lockCh;
      found = iCmdVld[lockCh];
    end
  end

  // A last=0 accept opens (or continues) a burst, a last=1 accept ends it.
  always_comb begin
    stateNext  = state;
    lockChNext = lockCh;
    if (accept) begin
      if (iCmdPld[grant][ADDR_W]) begin
        stateNext = ARB_OPEN;
      end else begin
        stateNext  = ARB_LOCKED;
        lockChNext = grant;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= ARB_OPEN;
      lockCh <= '0;
    end else begin
      state  <= stateNext;
      lockCh <= lockChNext;
    end
  end
`else
  logic unusedLast;

  assign grant = pick.grant;
  assign found = pick.found;

  // Without burst locking the last flag carries no meaning here.
  always_comb begin
    unusedLast = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      unusedLast = unusedLast ^ iCmdPld[c][ADDR_W];
    end
  end
`endif

  // Reset also masks the combinational grant so the outputs are quiet
  // for the whole reset period regardless of what the requesters drive.
  assign accept   = found && creditOk && !iRst;
  assign oCmdRdy  = accept ? (CH_NUM'(1) << grant) : '0;
  assign oMemRen  = accept;
  assign oMemAddr = accept ? iCmdPld[grant][ADDR_W-1:0] : '0;

  // Round-robin pointer plus the tag pipe that tracks which requester
  // each outstanding read belongs to until its data returns.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ptr    <= '0;
      tagVld <= '0;
      for (int k = 0; k < RD_LAT; k++) tagIdx[k] <= '0;
    end else begin
      if (accept) ptr <= grant + 4'd1;
      tagVld[0] <= accept;
      tagIdx[0] <= grant;
      for (int k = 1; k < RD_LAT; k++) begin
        tagVld[k] <= tagVld[k-1];
        tagIdx[k] <= tagIdx[k-1];
      end
    end
  end

  assign pushEntry.idx  = tagIdx[RD_LAT-1];
  assign pushEntry.data = iMemData;

  rd_arb_rsp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) rspFifo (
    .iClk     (iClk),
    .iRst     (iRst),
    .push     (tagVld[RD_LAT-1]),
    .pushEntry(pushEntry),
    .pop      (fifoPop),
    .head     (fifoHead),
    .empty    (fifoEmpty),
    .full     (fifoFull),
    .count    (fifoCount)
  );

  // Responses return strictly in order; only the head's owner can pop it.
  assign fifoPop  = !fifoEmpty && iRspRdy[fifoHead.idx];
  assign oRspVld  = fifoEmpty ? '0 : (CH_NUM'(1) << fifoHead.idx);
  assign oRspData = fifoHead.data;

  // The credit scheme must make a write into a full FIFO impossible.
  rspFifoNoOverflow: assert property (@(posedge iClk) disable iff (iRst)
    !(tagVld[RD_LAT-1] && fifoFull));

endmodule

// File: tb/tb_rd_cmd_arb16.sv
// tb_rd_cmd_arb16
//   Self-checking bench for rd_cmd_arb16. A transaction-level model keeps
//   the round-robin pointer and a queue of outstanding responses, and
//   predicts grants, memory requests and responses every cycle.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_rd_cmd_arb16;

  localparam int ADDR_W = 11;
  localparam int DW     = `DATA_WIDTH;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int NCH    = 16;

  logic                        iClk = 1'b0;
  logic                        iRst;
  logic [NCH-1:0]              iCmdVld;
  logic [NCH-1:0]              oCmdRdy;
  logic [NCH-1:0][ADDR_W:0]    iCmdPld;
  logic                        oMemRen;
  logic [ADDR_W-1:0]           oMemAddr;
  logic [DW-1:0]               iMemData;
  logic [NCH-1:0]              oRspVld;
  logic [DW-1:0]               oRspData;
  logic [NCH-1:0]              iRspRdy;

  rd_cmd_arb16 #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DW),
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iCmdVld (iCmdVld),
    .oCmdRdy (oCmdRdy),
    .iCmdPld (iCmdPld),
    .oMemRen (oMemRen),
    .oMemAddr(oMemAddr),
    .iMemData(iMemData),
    .oRspVld (oRspVld),
    .oRspData(oRspData),
    .iRspRdy (iRspRdy)
  );

  always #5 iClk = ~iClk;

  // Outstanding responses in accept order, each with the first cycle it
  // may be presented to its requester.
  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            readyCyc;
  } rspT;

  // Reads issued in recent cycles, used to play back memory data.
  typedef struct {
    bit                vld;
    logic [ADDR_W-1:0] addr;
  } issueT;

  rspT           rspQ[$];
  issueT         issueHist[$];
  logic [DW-1:0] memArr [1 << ADDR_W];
  int            mPtr;
  bit            mLocked;
  int            mLockCh;
  int            cyc;
  int            vectors;
  int            miscompares;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // Clear the model the way a reset clears the design.
  task automatic modelReset();
    issueT blank;
    blank.vld  = 1'b0;
    blank.addr = '0;
    rspQ.delete();
    issueHist.delete();
    for (int i = 0; i < RD_LAT; i++) issueHist.push_back(blank);
    mPtr    = 0;
    mLocked = 1'b0;
    mLockCh = 0;
  endtask

  task automatic randomPld();
    for (int c = 0; c < NCH; c++) iCmdPld[c] = (ADDR_W + 1)'($urandom);
  endtask

  // One clock cycle: drive inputs at the falling edge, let the
  // combinational paths settle, compare against the model, then advance
  // the model past the coming rising edge.
  task automatic applyStimulus(input logic [NCH-1:0] vld,
                               input logic [NCH-1:0] rdy);
    issueT          h;
    issueT          nowIssue;
    rspT            ent;
    int             g;
    bit             found;
    bit             accept;
    logic [NCH-1:0] expRdy;
    logic [NCH-1:0] expVld;
    logic [DW-1:0]  expData;
    logic [ADDR_W-1:0] expAddr;

    @(negedge iClk);
    h        = issueHist.pop_front();
    iCmdVld  = vld;
    iRspRdy  = rdy;
    iMemData = h.vld ? memArr[h.addr] : DW'($urandom);
    #1;

    found = 1'b0;
    g     = 0;
    if (mLocked) begin
      g     = mLockCh;
      found = vld[g];
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!found && vld[(mPtr + i) % NCH]) begin
          found = 1'b1;
          g     = (mPtr + i) % NCH;
        end
      end
    end
    accept  = found && (rspQ.size() < DEPTH);
    expRdy  = accept ? (NCH'(1) << g) : '0;
    expAddr = accept ? iCmdPld[g][ADDR_W-1:0] : '0;
    checkOutput("cmdRdy", 64'(oCmdRdy), 64'(expRdy));
    checkOutput("memRen", 64'(oMemRen), 64'(accept));
    checkOutput("memAddr", 64'(oMemAddr), 64'(expAddr));

    expVld  = '0;
    expData = '0;
    if (rspQ.size() > 0 && rspQ[0].readyCyc <= cyc) begin
      expVld  = NCH'(1) << rspQ[0].idx;
      expData = rspQ[0].data;
    end
    checkOutput("rspVld", 64'(oRspVld), 64'(expVld));
    if (expVld != '0) checkOutput("rspData", 64'(oRspData), 64'(expData));

    if (expVld != '0 && rdy[rspQ[0].idx]) rspQ.delete(0);
    if (accept) begin
      ent.idx      = g;
      ent.data     = memArr[expAddr];
      ent.readyCyc = cyc + RD_LAT + 1;
      rspQ.push_back(ent);
      mPtr = (g + 1) % NCH;
`ifdef RDARB_BURST_LOCK_EN
      mLocked = !iCmdPld[g][ADDR_W];
      mLockCh = g;
`endif
    end
    nowIssue.vld  = accept;
    nowIssue.addr = expAddr;
    issueHist.push_back(nowIssue);
    cyc++;
  endtask

  // Assert reset asynchronously mid-cycle and confirm every output is
  // quiet immediately and stays quiet until release.
  task automatic doReset(input int nCycles);
    @(negedge iClk);
    iRst    = 1'b1;
    iCmdVld = '0;
    iRspRdy = '0;
    modelReset();
    for (int n = 0; n <= nCycles; n++) begin
      #1;
      checkOutput("rstCmdRdy", 64'(oCmdRdy), 64'd0);
      checkOutput("rstMemRen", 64'(oMemRen), 64'd0);
      checkOutput("rstMemAddr", 64'(oMemAddr), 64'd0);
      checkOutput("rstRspVld", 64'(oRspVld), 64'd0);
      checkOutput("rstRspData", 64'(oRspData), 64'd0);
      @(negedge iClk);
    end
    iRst = 1'b0;
  endtask

  initial begin
    iRst        = 1'b1;
    iCmdVld     = '0;
    iRspRdy     = '0;
    iCmdPld     = '0;
    iMemData    = '0;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    for (int a = 0; a < (1 << ADDR_W); a++) memArr[a] = DW'($urandom);
    memArr[11'h1A3] = DW'(32'hDEAD);
    modelReset();
    doReset(2);

    // Lone request from channel 5 to address 0x1A3.
    randomPld();
    iCmdPld[5] = {1'b1, 11'h1A3};
    applyStimulus(16'h0020, '1);
    for (int i = 0; i < 6; i++) applyStimulus('0, '1);

    // Every channel requesting continuously with responses always taken.
    for (int i = 0; i < 40; i++) begin
      randomPld();
      for (int c = 0; c < NCH; c++) iCmdPld[c][ADDR_W] = 1'b1;
      applyStimulus('1, '1);
    end
    for (int i = 0; i < 6; i++) applyStimulus('0, '1);

    // Responses blocked: credits run out, then drain and resume.
    for (int i = 0; i < 12; i++) begin
      randomPld();
      for (int c = 0; c < NCH; c++) iCmdPld[c][ADDR_W] = 1'b1;
      applyStimulus('1, '0);
    end
    for (int i = 0; i < 12; i++) begin
      randomPld();
      for (int c = 0; c < NCH; c++) iCmdPld[c][ADDR_W] = 1'b1;
      applyStimulus('1, '1);
    end
    for (int i = 0; i < 6; i++) applyStimulus('0, '1);

    // Grant channel 9 alone to park the pointer at 10, then race 3 and 9.
    randomPld();
    iCmdPld[9][ADDR_W] = 1'b1;
    iCmdPld[3][ADDR_W] = 1'b1;
    applyStimulus(16'h0200, '1);
    for (int i = 0; i < 5; i++) applyStimulus('0, '1);
    applyStimulus(16'h0208, '1);
    applyStimulus(16'h0208, '1);
    for (int i = 0; i < 6; i++) applyStimulus('0, '1);

`ifdef RDARB_BURST_LOCK_EN
    // Channel 2 burst of three while channel 7 keeps asking.
    for (int b = 0; b < 4; b++) begin
      randomPld();
      iCmdPld[2][ADDR_W] = (b >= 2);
      iCmdPld[7][ADDR_W] = 1'b1;
      applyStimulus(16'h0084, '1);
    end
    for (int i = 0; i < 6; i++) applyStimulus('0, '1);
`endif

    // Reset with two reads still in flight.
    randomPld();
    for (int c = 0; c < NCH; c++) iCmdPld[c][ADDR_W] = 1'b1;
    applyStimulus(16'h0002, '1);
    applyStimulus(16'h0004, '1);
    doReset(2);
    for (int i = 0; i < 6; i++) applyStimulus('0, '1);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      randomPld();
      applyStimulus(NCH'($urandom) & NCH'($urandom), NCH'($urandom | $urandom));
    end
    for (int i = 0; i < 30; i++) applyStimulus('0, '1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rd_cmd_arb16.md
# rd_cmd_arb16

Round-robin arbiter sharing one fixed-latency packet-buffer read port among the 16 per-port read controllers. Each controller presents read commands. The arbiter grants one command per cycle, issues it to the memory, and tags it with the requester index. It returns the read data to that requester through a credit-protected response FIFO. It sits between the 16 read-channel command/data Decoupled links and the shared SRAM read port.

## Interface
Parameters:
- ADDR_W, 11: memory address width.
- DATA_W, `DATA_WIDTH: read data width.
- RD_LAT, 2: fixed memory read latency in cycles, ≥1.
- FIFO_DEPTH, 4: response FIFO entries, power of two, ≥2.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset, asynchronous, active-high.
- iCmdVld[16]  in  1  command valid per channel.
- oCmdRdy[16]  out  1  command ready per channel.
- iCmdPld[16]  in  ADDR_W+1  {last, addr}.
- oMemRen  out  1  memory read enable.
- oMemAddr  out  ADDR_W  memory read address.
- iMemData  in  DATA_W  memory data, valid RD_LAT cycles after oMemRen.
- oRspVld[16]  out  1  response valid per channel.
- oRspData  out  DATA_W  response data, shared by all channels.
- iRspRdy[16]  in  1  response ready per channel.

## Operation
Credits:
- inflight = tag-pipe valid count + FIFO count.
- Issue is permitted only when inflight < FIFO_DEPTH.
- A FIFO pop in the same cycle does not free a credit until the next cycle. The count is conservative.

Arbitration:
- Combinational round-robin over iCmdVld. Search starts at ptr and wraps from 15 to 0.
- oCmdRdy is one-hot on the granted channel, or all zero when no request is pending or no credit is available.
- Accept = iCmdVld[g] & oCmdRdy[g].
- On accept: ptr ← g+1 mod 16, oMemRen=1, oMemAddr=iCmdPld[g][ADDR_W-1:0].

Tag pipe:
- RD_LAT-stage shift register of {valid, idx[3:0]}.
- Stage RD_LAT-1 valid writes {idx, iMemData} into the FIFO that same cycle.

Response FIFO (sub-module):
- When not empty, the head drives oRspVld[head.idx]=1; all other channels are 0.
- oRspData = head.data.
- Pop when iRspRdy[head.idx]=1.
- Strict in-order return. A stalled head blocks all channels (accepted head-of-line blocking).

Boundary conditions:
- FIFO cannot overflow by construction. A write into a full FIFO is an assertion failure.
- Simultaneous FIFO push and pop: count is unchanged.
- No requests: ptr holds.

## Timing
- Reset values: oCmdRdy=0, oMemRen=0, oMemAddr=0, oRspVld=0, oRspData=0, ptr=0, tag valids=0, FIFO empty.
- oCmdRdy and oMemRen/oMemAddr are combinational from iCmdVld, ptr and credits. Accept cycle T issues the memory read in cycle T.
- iMemData is sampled at T+RD_LAT. oRspVld rises at T+RD_LAT+1, because the FIFO output is registered.
- Sustained throughput is 1 command/cycle when FIFO_DEPTH ≥ RD_LAT+2. Otherwise throughput is credit-limited.
- Reset mid-operation: in-flight tags and FIFO contents are discarded immediately. Requesters must also be in reset.

## Configuration
RDARB_BURST_LOCK_EN:
- Defined: after accepting a command with last=0 from channel c, the grant locks on c, with oCmdRdy[c] only, until a command with last=1 from c is accepted. ptr then advances to c+1. Credit stalls still apply while locked.
- Undefined: the last bit is ignored, and every accept re-arbitrates.

## Structure
- Shared package rd_arb_pkg holds:
  - typedef rsp_entry_t {logic [3:0] idx; logic [DATA_W-1:0] data;}
  - localparam CH_NUM=16
  - function rr_pick (16-bit request, 4-bit ptr → 4-bit grant + found).
- One sub-module, rd_arb_rsp_fifo: synchronous FIFO of rsp_entry_t with registered head, count output, and full/empty.

## Test plan
- Single request: ch5 sends addr 0x1A3, RD_LAT=2, iMemData=0xDEAD at T+2 → oMemRen at T, oRspVld[5] at T+3 with data 0xDEAD; all other oRspVld stay 0.
- All 16 channels request continuously, iRspRdy all 1 → grants are 0,1,…,15,0 with exactly one grant per cycle and responses in grant order.
- iRspRdy held 0, FIFO_DEPTH=4 → exactly 4 accepts, then oCmdRdy all 0. Releasing ready drains 4 responses and issue resumes the cycle after the first pop.
- Ch3 and ch9 requesting with ptr=10 → ch3 granted first, then ch9.
- RDARB_BURST_LOCK_EN: ch2 sends last=0,0,1 while ch7 requests → ch2 gets three consecutive grants, then ch7.
- Assert iRst while 2 reads are in flight → all outputs 0 next edge, and no stale oRspVld after reset release.
